run_ctrl: RTL and testbench

- Test-run sequencer for the compiled node array and its stream rows (input row of four streams, output checkers).
- Holds the datapath in reset while idle.
- On start, clears the datapath, releases it, counts run cycles and watches the output checkers.
- Ends the run on completion, mismatch, abort or timeout, and latches a result for the host interface.

---
 rtl/tis_run_pkg.sv | 20 ++
 rtl/sat_counter.sv | 36 +++
 rtl/run_ctrl.sv | 157 +++++++++++++++
 tb/tb_run_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tis_run_pkg.sv
// Shared types and constants for the test-run sequencer.
// Result bit positions define how run results pack into a host status word.
package tis_run_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_CLEAR,
        RS_RUN,
        RS_DONE
    } run_state_t;

    localparam int unsigned NSTREAMS_DEFAULT = 4;

    localparam int unsigned RES_DONE    = 0;
    localparam int unsigned RES_PASS    = 1;
    localparam int unsigned RES_TIMEOUT = 2;
    localparam int unsigned RES_STALL   = 3;
    localparam int unsigned RES_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter with synchronous clear and saturation at all-ones.
// count_inc is the saturated successor of the current count, for look-ahead compares.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_inc
);

    logic [W-1:0] count_q, count_d;

    assign count_inc = (&count_q) ? count_q : count_q + W'(1);
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Test-run sequencer: holds the datapath in reset, clears/releases it on start, watches the
// output checkers and latches the run result. Stall detection is built with RUN_CTRL_STALL_DETECT_EN.
module run_ctrl
    import tis_run_pkg::*;
#(
    parameter int unsigned NSTREAMS     = NSTREAMS_DEFAULT,
    parameter int unsigned CYCW         = 20,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned STALL_LIMIT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CYCW-1:0]     timeout_lim,
    input  logic [NSTREAMS-1:0] out_used,
    input  logic [NSTREAMS-1:0] out_done,
    input  logic [NSTREAMS-1:0] out_mismatch,
    input  logic                activity,
    output logic                sys_rst,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timed_out,
    output logic                stalled,
    output logic [CYCW-1:0]     cycles
);

    localparam int unsigned CLRW = $clog2(CLEAR_CYCLES + 1);

    run_state_t        state_q, state_d;
    logic [CLRW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              sys_rst_q, sys_rst_d;
    logic              busy_q, busy_d;
    logic              cyc_clr;
    logic [CYCW-1:0]   cyc_inc;
    logic              any_mismatch, all_done, timeout_hit, stall_hit;

    sat_counter #(
        .W (CYCW)
    ) u_cycles (
        .clk       (clk),
        .rst       (rst),
        .clr       (cyc_clr),
        .inc       (state_q == RS_RUN),
        .count     (cycles),
        .count_inc (cyc_inc)
    );

`ifdef RUN_CTRL_STALL_DETECT_EN
    localparam int unsigned STW = $clog2(STALL_LIMIT + 1);

    logic [STW-1:0] stall_inc, stall_next, unused_stall_cnt;

    // Held at zero outside RUN, so every run starts with a fresh count.
    sat_counter #(
        .W (STW)
    ) u_stall (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state_q != RS_RUN) || activity),
        .inc       (state_q == RS_RUN),
        .count     (unused_stall_cnt),
        .count_inc (stall_inc)
    );

    assign stall_next = activity ? '0 : stall_inc;
    assign stall_hit  = (stall_next == STW'(STALL_LIMIT));
`else
    logic unused_stall;

    assign unused_stall = activity | (STALL_LIMIT == 0);
    assign stall_hit    = 1'b0;
`endif

    assign any_mismatch = |(out_mismatch & out_used);
    assign all_done     = ((out_done & out_used) == out_used);
    assign timeout_hit  = (timeout_lim != '0) && (cyc_inc == timeout_lim);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        res_d     = res_q;
        cyc_clr   = 1'b0;

        unique case (state_q)
            RS_IDLE, RS_DONE: begin
                if (start) begin
                    state_d   = RS_CLEAR;
                    clr_cnt_d = CLRW'(CLEAR_CYCLES);
                    res_d     = '0;
                    cyc_clr   = 1'b1;
                end
            end
            RS_CLEAR: begin
                if (abort) begin
                    state_d = RS_IDLE;
                end else if (clr_cnt_q <= CLRW'(1)) begin
                    state_d = RS_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q - CLRW'(1);
                end
            end
            RS_RUN: begin
                if (abort) begin
                    state_d        = RS_IDLE;
                    res_d[RES_PASS] = 1'b0;
                end else if (any_mismatch) begin
                    state_d         = RS_DONE;
                    res_d[RES_PASS] = 1'b0;
                end else if (all_done) begin
                    state_d         = RS_DONE;
                    res_d[RES_PASS] = 1'b1;
                end else if (stall_hit) begin
                    state_d          = RS_DONE;
                    res_d[RES_STALL] = 1'b1;
                end else if (timeout_hit) begin
                    state_d            = RS_DONE;
                    res_d[RES_TIMEOUT] = 1'b1;
                end
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        res_d[RES_DONE] = (state_d == RS_DONE);
        busy_d          = (state_d == RS_CLEAR) || (state_d == RS_RUN);
        sys_rst_d       = (state_d != RS_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RS_IDLE;
            clr_cnt_q <= '0;
            res_q     <= '0;
            sys_rst_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            res_q     <= res_d;
            sys_rst_q <= sys_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign sys_rst   = sys_rst_q;
    assign busy      = busy_q;
    assign done      = res_q[RES_DONE];
    assign pass      = res_q[RES_PASS];
    assign timed_out = res_q[RES_TIMEOUT];
    assign stalled   = res_q[RES_STALL];

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: table of run scenarios plus hand-written corner sequences.
// Stall expectations switch with RUN_CTRL_STALL_DETECT_EN (bench uses STALL_LIMIT=16).
module tb_run_ctrl;

    localparam int unsigned CYCW = 20;
    localparam int unsigned CC   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CYCW-1:0] timeout_lim = '0;
    logic [3:0]      out_used = '0;
    logic [3:0]      out_done = '0;
    logic [3:0]      out_mismatch = '0;
    logic            activity = 1'b0;
    logic            sys_rst, busy, done, pass, timed_out, stalled;
    logic [CYCW-1:0] cycles;

    int total = 0;
    int bad   = 0;

    run_ctrl #(
        .NSTREAMS     (4),
        .CYCW         (CYCW),
        .CLEAR_CYCLES (CC),
        .STALL_LIMIT  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .timeout_lim  (timeout_lim),
        .out_used     (out_used),
        .out_done     (out_done),
        .out_mismatch (out_mismatch),
        .activity     (activity),
        .sys_rst      (sys_rst),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timed_out    (timed_out),
        .stalled      (stalled),
        .cycles       (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] used;
        logic [3:0] noise_done;
        logic [3:0] noise_mm;
        int         done_at;
        int         mm_at;
        int         to;
        int         abort_at;
        int         start_at;
        int         act_per;
        int         exp_cycles;
        logic       exp_done;
        logic       exp_pass;
        logic       exp_to;
        logic       exp_st;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        int   n;
        bit   exited;
        v = vecs[idx];
        out_used     = v.used;
        out_done     = v.noise_done;
        out_mismatch = v.noise_mm;
        timeout_lim  = CYCW'(v.to);
        activity     = 1'b0;
        do_start();
        // Results cleared on start, whether from IDLE or DONE.
        chk($sformatf("v%0d clear_busy", idx), busy, 1);
        chk($sformatf("v%0d clear_sysrst", idx), sys_rst, 1);
        chk($sformatf("v%0d clear_res", idx), {done, pass, timed_out, stalled}, 0);
        chk($sformatf("v%0d clear_cycles", idx), cycles, 0);
        k = 0;
        while (sys_rst && k < 10) begin
            tick();
            k++;
        end
        chk($sformatf("v%0d clear_len", idx), k, CC);
        exited = 1'b0;
        n = 0;
        while (!exited && n < 60) begin
            n++;
            out_done = (v.done_at != 0 && n >= v.done_at) ? 4'b1111 : v.noise_done;
            out_mismatch = (v.mm_at != 0 && n >= v.mm_at) ? 4'b0010 : v.noise_mm;
            abort    = (n == v.abort_at);
            start    = (n == v.start_at);
            activity = (v.act_per != 0) && (n % v.act_per == 0);
            tick();
            exited = sys_rst;
        end
        abort = 1'b0;
        start = 1'b0;
        activity = 1'b0;
        chk($sformatf("v%0d run_len", idx), n, v.exp_cycles);
        chk($sformatf("v%0d cycles", idx), cycles, v.exp_cycles);
        chk($sformatf("v%0d done", idx), done, v.exp_done);
        chk($sformatf("v%0d pass", idx), pass, v.exp_pass);
        chk($sformatf("v%0d timed_out", idx), timed_out, v.exp_to);
        chk($sformatf("v%0d stalled", idx), stalled, v.exp_st);
        chk($sformatf("v%0d busy_after", idx), busy, 0);
        out_done = '0;
        out_mismatch = '0;
        tick();
        chk($sformatf("v%0d held_done", idx), done, v.exp_done);
        chk($sformatf("v%0d held_cycles", idx), cycles, v.exp_cycles);
    endtask

    initial begin
        // used, ndone, nmm, done_at, mm_at, to, abort_at, start_at, act_per, cyc, d, p, to, st
        vecs[0] = '{4'b0011, 4'b0000, 4'b0000, 10, 0, 0, 0, 4, 0, 10, 1, 1, 0, 0};
        vecs[1] = '{4'b0011, 4'b0000, 4'b0000, 5, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0};
        vecs[2] = '{4'b0011, 4'b0000, 4'b0000, 0, 0, 7, 0, 0, 0, 7, 1, 0, 1, 0};
        vecs[3] = '{4'b0011, 4'b0000, 4'b0000, 7, 0, 7, 0, 0, 0, 7, 1, 1, 0, 0};
        vecs[4] = '{4'b0011, 4'b0000, 4'b0000, 0, 0, 0, 3, 0, 0, 3, 0, 0, 0, 0};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        vecs[6] = '{4'b1100, 4'b0011, 4'b0001, 4, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0};
`ifdef RUN_CTRL_STALL_DETECT_EN
        vecs[7] = '{4'b0001, 4'b0000, 4'b0000, 0, 0, 20, 0, 0, 0, 16, 1, 0, 0, 1};
`else
        vecs[7] = '{4'b0001, 4'b0000, 4'b0000, 0, 0, 20, 0, 0, 0, 20, 1, 0, 1, 0};
`endif
        vecs[8] = '{4'b0001, 4'b0000, 4'b0000, 0, 0, 30, 0, 0, 10, 30, 1, 0, 1, 0};

        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("reset sys_rst", sys_rst, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cycles", cycles, 0);
        chk("reset flags", {pass, timed_out, stalled}, 0);

        for (int i = 0; i < 9; i++) run_vec(i);

        // Abort is ignored in DONE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("done_abort done", done, 1);
        chk("done_abort to", timed_out, 1);

        // Abort during CLEAR returns to IDLE.
        out_used = 4'b0001;
        timeout_lim = '0;
        do_start();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("clr_abort busy", busy, 0);
        chk("clr_abort sys_rst", sys_rst, 1);
        chk("clr_abort done", done, 0);
        tick();
        tick();
        chk("clr_abort stays", {busy, sys_rst}, 2'b01);

        // Synchronous reset mid-run forces idle values.
        do_start();
        for (int i = 0; i < CC + 4; i++) tick();
        chk("mid sys_rst low", sys_rst, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst sys_rst", sys_rst, 1);
        chk("midrst busy", busy, 0);
        chk("midrst cycles", cycles, 0);
        chk("midrst done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
